gates7_dataflow: RTL and testbench
==================================

Name: gates7_dataflow

Overview:
- Bitwise two-input logic-gate block that evaluates the seven basic gate functions (AND, OR, NOT, NAND, NOR, XOR, XNOR) of operands a and b.
- Provides two result sets:
  - combinational dataflow outputs (f_*), which follow the inputs with zero latency;
  - a registered copy (r_*) with a valid flag, for use in clocked pipelines.
- Used as the reference logic-gate primitive in basic logic-circuit designs and benches.

Parameters:
- WIDTH, 1, bit width of operands a, b and of every result output; all operations are bitwise.

Ports:
- clk      input   1      rising-edge clock; used only by the registered outputs
- rst      input   1      synchronous active-high reset
- a        input   WIDTH  operand A
- b        input   WIDTH  operand B
- in_valid input   1      qualifies a/b for capture into the registered outputs
- f_and    output  WIDTH  a & b, combinational
- f_or     output  WIDTH  a | b, combinational
- f_not    output  WIDTH  ~a, combinational; b is unused for this output
- f_nand   output  WIDTH  ~(a & b), combinational
- f_nor    output  WIDTH  ~(a | b), combinational
- f_xor    output  WIDTH  a ^ b, combinational
- f_xnor   output  WIDTH  ~(a ^ b), combinational
- r_and, r_or, r_not, r_nand, r_nor, r_xor, r_xnor   output  WIDTH  registered versions of the matching f_* outputs
- out_valid output 1      high for one cycle when the r_* outputs hold a newly captured result

Behaviour:
- f_* outputs:
  - Pure continuous-assignment dataflow: no clock, no reset, no storage.
  - Must settle within the same simulation timestep as an a/b change.
  - Independent of rst, clk and in_valid.
- Truth table per bit (a,b -> and or not nand nor xor xnor):
  - 0,0 -> 0 0 1 1 1 0 1
  - 0,1 -> 0 1 1 1 0 1 0
  - 1,0 -> 0 1 0 1 0 1 0
  - 1,1 -> 1 1 0 0 0 0 1
- Invariants that hold for every input:
  - f_nand == ~f_and
  - f_nor == ~f_or
  - f_xnor == ~f_xor
  - f_not depends on a only.
- X/Z inputs propagate using standard Verilog operator semantics; no special handling.
- Registered path, evaluated on each rising clk:
  - If rst = 1: all r_* outputs <= 0 and out_valid <= 0. This applies regardless of in_valid.
  - Else if in_valid = 1: every r_* output <= the matching f_* value of the current a/b, and out_valid <= 1.
  - Else: r_* outputs hold their values and out_valid <= 0.
- Latency: r_* outputs reflect the a/b sampled at edge N, visible after edge N. This is one cycle.
- Reset value of every output:
  - r_* outputs: all zeros. This includes r_not, r_nand, r_nor and r_xnor, even though their combinational counterparts read 1 for a=b=0.
  - out_valid: 0.
  - f_* outputs: no reset value; they always reflect the current inputs.
- Reset asserted mid-operation:
  - At the next edge the registered state is cleared.
  - A capture that coincides with rst is discarded.
- Back-to-back in_valid: each cycle captures a new result, and out_valid stays high continuously.
- No handshake backpressure; captured results are overwritten freely.
- Width rule: every output is exactly WIDTH bits and every operation is bitwise. There is no carry, reduction or sign extension.

Test Plan:
- Exhaustive toggle, WIDTH=1, with a toggling every 1 ns and b every 2 ns, starting a=0, b=0 -> f_* outputs follow the truth table above in every interval, with zero delay.
- Invariant sweep, WIDTH=8, for a,b in {00,FF,A5,5A,3C} -> f_and=a&b, f_not=~a, f_nand=~f_and, f_nor=~f_or, f_xnor=~f_xor.
  - Example: a=A5, b=3C -> f_and=24, f_or=BD, f_xor=99, f_not=5A.
- Reset, with rst=1 for 2 cycles and a=b=0 -> r_* all 0 and out_valid=0, while f_not=1, f_nand=1, f_nor=1, f_xnor=1.
- Registered capture, with a=1, b=0, in_valid=1 for one cycle -> after the edge r_or=1, r_xor=1, r_nand=1, r_and=0, r_xnor=0, and out_valid=1 for exactly one cycle. With in_valid=0 the values then hold and out_valid=0.
- Reset mid-stream, with in_valid=1 and rst=1 at the same edge and a=b=1 -> r_* stay 0 and out_valid=0. On the next edge with rst=0: r_and=1, r_xnor=1, out_valid=1.
- Streaming, with in_valid held 1 while a/b change every cycle -> each r_* equals the previous cycle's f_*, and out_valid stays 1 continuously.

Source files
------------

// File: rtl/gates7_dataflow.sv
// Seven bitwise two-input gate functions: zero-latency dataflow outputs (f_*)
// plus a registered copy (r_*) qualified by a one-cycle out_valid pulse.
module gates7_dataflow #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] f_and,
  output logic [WIDTH-1:0] f_or,
  output logic [WIDTH-1:0] f_not,
  output logic [WIDTH-1:0] f_nand,
  output logic [WIDTH-1:0] f_nor,
  output logic [WIDTH-1:0] f_xor,
  output logic [WIDTH-1:0] f_xnor,
  output logic [WIDTH-1:0] r_and,
  output logic [WIDTH-1:0] r_or,
  output logic [WIDTH-1:0] r_not,
  output logic [WIDTH-1:0] r_nand,
  output logic [WIDTH-1:0] r_nor,
  output logic [WIDTH-1:0] r_xor,
  output logic [WIDTH-1:0] r_xnor,
  output logic             out_valid
);

  typedef struct packed {
    logic [WIDTH-1:0] g_and;
    logic [WIDTH-1:0] g_or;
    logic [WIDTH-1:0] g_not;
    logic [WIDTH-1:0] g_nand;
    logic [WIDTH-1:0] g_nor;
    logic [WIDTH-1:0] g_xor;
    logic [WIDTH-1:0] g_xnor;
  } gates_t;

  gates_t f_res, r_res;
  logic   vld_q;

  assign f_res.g_and  = a & b;
  assign f_res.g_or   = a | b;
  assign f_res.g_not  = ~a;
  assign f_res.g_nand = ~(a & b);
  assign f_res.g_nor  = ~(a | b);
  assign f_res.g_xor  = a ^ b;
  assign f_res.g_xnor = ~(a ^ b);

  assign f_and  = f_res.g_and;
  assign f_or   = f_res.g_or;
  assign f_not  = f_res.g_not;
  assign f_nand = f_res.g_nand;
  assign f_nor  = f_res.g_nor;
  assign f_xor  = f_res.g_xor;
  assign f_xnor = f_res.g_xnor;

  // Reset clears everything, including gates whose combinational value is 1 at a=b=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
      vld_q <= 1'b0;
    end else begin
      if (in_valid) r_res <= f_res;
      vld_q <= in_valid;
    end
  end

  assign r_and     = r_res.g_and;
  assign r_or      = r_res.g_or;
  assign r_not     = r_res.g_not;
  assign r_nand    = r_res.g_nand;
  assign r_nor     = r_res.g_nor;
  assign r_xor     = r_res.g_xor;
  assign r_xnor    = r_res.g_xnor;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_gates7_dataflow.sv
// Bench for gates7_dataflow: WIDTH=8 instance for functional/registered checks,
// WIDTH=1 instance for the exhaustive toggle; reference built from the truth table.
`timescale 1ns/100ps
module tb_gates7_dataflow;
  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor;
  logic [7:0] r_and, r_or, r_not, r_nand, r_nor, r_xor, r_xnor;
  logic out_valid;

  gates7_dataflow #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .f_and(f_and), .f_or(f_or), .f_not(f_not), .f_nand(f_nand),
    .f_nor(f_nor), .f_xor(f_xor), .f_xnor(f_xnor),
    .r_and(r_and), .r_or(r_or), .r_not(r_not), .r_nand(r_nand),
    .r_nor(r_nor), .r_xor(r_xor), .r_xnor(r_xnor), .out_valid(out_valid));

  logic a1 = 1'b0, b1 = 1'b0;
  logic g_and, g_or, g_not, g_nand, g_nor, g_xor, g_xnor;
  logic s_and, s_or, s_not, s_nand, s_nor, s_xor, s_xnor, s_vld;

  gates7_dataflow #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(1'b1), .a(a1), .b(b1), .in_valid(1'b0),
    .f_and(g_and), .f_or(g_or), .f_not(g_not), .f_nand(g_nand),
    .f_nor(g_nor), .f_xor(g_xor), .f_xnor(g_xnor),
    .r_and(s_and), .r_or(s_or), .r_not(s_not), .r_nand(s_nand),
    .r_nor(s_nor), .r_xor(s_xor), .r_xnor(s_xnor), .out_valid(s_vld));

  // Truth table rows indexed by {a,b}; bits [6:0] = and or not nand nor xor xnor.
  logic [6:0] tt [4];
  initial begin
    tt[0] = 7'b0011101;
    tt[1] = 7'b0111010;
    tt[2] = 7'b0101010;
    tt[3] = 7'b1100001;
  end

  function automatic logic [55:0] ref8(input logic [7:0] x, input logic [7:0] y);
    logic [55:0] res;
    logic [6:0] row;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      row = tt[{x[i], y[i]}];
      for (int g = 0; g < 7; g++) res[g*8 + i] = row[g];
    end
    return res;
  endfunction

  logic [55:0] m_r = '0;
  logic        m_v = 1'b0;

  function automatic logic [55:0] obs_f();
    return {f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor};
  endfunction
  function automatic logic [55:0] obs_r();
    return {r_and, r_or, r_not, r_nand, r_nor, r_xor, r_xnor};
  endfunction

  // Advance one clock and update the reference registered state from the driven inputs.
  task automatic step();
    @(posedge clk);
    if (rst) begin m_r = '0; m_v = 1'b0; end
    else begin
      if (in_valid) m_r = ref8(a, b);
      m_v = in_valid;
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
    step(); step();
    checks++;
    if (obs_r() !== 56'h0) begin failures++; $display("FAIL reset_r got=%h exp=0", obs_r()); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", out_valid); end
    checks++;
    if ({f_not, f_nand, f_nor, f_xnor} !== 32'hFFFFFFFF)
      begin failures++; $display("FAIL reset_f1 got=%h exp=ffffffff", {f_not, f_nand, f_nor, f_xnor}); end
    checks++;
    if ({f_and, f_or, f_xor} !== 24'h0)
      begin failures++; $display("FAIL reset_f0 got=%h exp=0", {f_and, f_or, f_xor}); end
  endtask

  task automatic test_toggle();
    logic [6:0] obs;
    for (int t = 0; t < 8; t++) begin
      a1 = t[0]; b1 = t[1];
      #0.5;
      obs = {g_and, g_or, g_not, g_nand, g_nor, g_xor, g_xnor};
      checks++;
      if (obs !== tt[{a1, b1}])
        begin failures++; $display("FAIL toggle a=%b b=%b got=%b exp=%b", a1, b1, obs, tt[{a1, b1}]); end
      #0.5;
    end
  endtask

  task automatic test_sweep();
    logic [7:0] v [5];
    v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'hA5; v[3] = 8'h5A; v[4] = 8'h3C;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        a = v[i]; b = v[j]; #1;
        checks++;
        if (obs_f() !== ref8(a, b))
          begin failures++; $display("FAIL sweep a=%h b=%h got=%h exp=%h", a, b, obs_f(), ref8(a, b)); end
      end
    a = 8'hA5; b = 8'h3C; #1;
    checks++;
    if ({f_and, f_or, f_xor, f_not} !== 32'h24BD995A)
      begin failures++; $display("FAIL sweep_a5_3c got=%h exp=24bd995a", {f_and, f_or, f_xor, f_not}); end
  endtask

  task automatic test_capture();
    @(negedge clk); rst = 1'b0; a = 8'h01; b = 8'h00; in_valid = 1'b1;
    step();
    checks++;
    if (obs_r() !== m_r) begin failures++; $display("FAIL capture_r got=%h exp=%h", obs_r(), m_r); end
    checks++;
    if ({r_or[0], r_xor[0], r_nand[0], r_and[0], r_xnor[0], out_valid} !== 6'b111001)
      begin failures++; $display("FAIL capture_bits got=%b exp=111001",
        {r_or[0], r_xor[0], r_nand[0], r_and[0], r_xnor[0], out_valid}); end
    @(negedge clk); in_valid = 1'b0; a = 8'hC3; b = 8'h77;
    step();
    checks++;
    if (obs_r() !== m_r || out_valid !== 1'b0)
      begin failures++; $display("FAIL capture_hold got=%h/%b exp=%h/0", obs_r(), out_valid, m_r); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); rst = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h01;
    step();
    checks++;
    if (obs_r() !== 56'h0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL rstmid_clear got=%h/%b exp=0/0", obs_r(), out_valid); end
    @(negedge clk); rst = 1'b0;
    step();
    checks++;
    if (r_and !== 8'h01 || r_xnor !== 8'hFF || out_valid !== 1'b1)
      begin failures++; $display("FAIL rstmid_cap got=%h/%h/%b exp=01/ff/1", r_and, r_xnor, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] prev_f;
    @(negedge clk); in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
    for (int k = 0; k < 40; k++) begin
      #0.5; prev_f = ref8(a, b);
      step();
      checks++;
      if (obs_r() !== prev_f || out_valid !== 1'b1)
        begin failures++; $display("FAIL stream k=%0d got=%h/%b exp=%h/1", k, obs_r(), out_valid, prev_f); end
      @(negedge clk); a = 8'($urandom); b = 8'($urandom);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      in_valid = 1'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (obs_f() !== ref8(a, b))
        begin failures++; $display("FAIL rand_f k=%0d got=%h exp=%h", k, obs_f(), ref8(a, b)); end
      step();
      checks++;
      if (obs_r() !== m_r || out_valid !== m_v)
        begin failures++; $display("FAIL rand_r k=%0d got=%h/%b exp=%h/%b", k, obs_r(), out_valid, m_r, m_v); end
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_sweep();
    test_capture();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
